apb2axi_bridge: RTL
===================

APB2AXI_BRIDGE -- requirements
Module: apb2axi_bridge

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI data width; legal values are 32 and 64.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 6, AXI ID width; AXI_USER_WIDTH, default 6, AXI user width.
REQ-004 SHALL have parameter APB_ADDR_WIDTH, default 32, APB address width; APB data width is fixed at 32.
REQ-005 clk_i  in  1  single clock; all logic rising-edge.
REQ-006 rst_ni  in  1  reset; synchronous, active-low.
REQ-007 s00_paddr  in  APB_ADDR_WIDTH  APB address.
REQ-008 s00_pwdata  in  32  APB write data.
REQ-009 s00_pwrite / s00_psel / s00_penable  in  1 each  APB control.
REQ-010 s00_pstrb  in  4  APB4 byte strobe; present only under APB2AXI_PSTRB_EN.
REQ-011 s00_prdata  out  32  read data.
REQ-012 s00_pready / s00_pslverr  out  1 each  transfer done / error.
REQ-013 m00_aw_addr, m00_ar_addr  out  AXI_ADDR_WIDTH  AXI addresses.
REQ-014 m00_aw_valid/m00_ar_valid out, m00_aw_ready/m00_ar_ready in, 1 each.
REQ-015 m00_w_data  out  AXI_DATA_WIDTH; m00_w_strb  out  AXI_DATA_WIDTH/8; m00_w_last  out  1, tied 1.
REQ-016 m00_w_valid out, m00_w_ready in; m00_b_valid in, m00_b_ready out; m00_b_resp in 2.
REQ-017 m00_r_data  in  AXI_DATA_WIDTH; m00_r_resp  in  2; m00_r_valid in, m00_r_ready out.
REQ-018 aw/ar id, len, lock, cache, prot, qos, region, user SHALL be driven constant 0; burst SHALL be 2'b01; size SHALL be 3'b010; b_id, r_id, r_last and user inputs SHALL be ignored.

Function
REQ-019 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-020 IDLE with psel=1 and penable=0:
- capture paddr, pwdata, pwrite and strobe.
- go to WR_REQ if pwrite=1, else RD_REQ.
- penable=1 without a prior setup phase is ignored.
REQ-021 Address handling: m00_*_addr SHALL be the captured paddr with bits [1:0] forced 0, zero-extended or truncated to AXI_ADDR_WIDTH.
REQ-022 WR_REQ:
- aw_valid and w_valid assert in the cycle after setup.
- Each is held until its own handshake; AW and W complete independently, in either order or in the same cycle.
- When both are done, go to WR_RESP.
REQ-023 WR_RESP: b_ready=1; on b_valid, capture b_resp and go to DONE.
REQ-024 RD_REQ: ar_valid held until ar_ready, then go to RD_RESP.
REQ-025 RD_RESP: r_ready=1; on r_valid, capture r_data lane and r_resp, then go to DONE.
REQ-026 DONE: pready=1 for exactly one cycle, with prdata = captured data (0 for writes) and pslverr = captured resp[1]; then go to IDLE.
REQ-027 If psel=0 in DONE, pready SHALL stay 0 and the FSM SHALL return to IDLE; an AXI transaction already issued always completes.
REQ-028 For 64-bit AXI: w_data = {pwdata, pwdata}; strobe placed in the upper lane when paddr[2]=1, lower lane otherwise, other lane 0; read lane selected by captured paddr[2].
REQ-029 pready SHALL be 0 in all states except DONE; minimum transfer latency setup-to-pready is 4 cycles with all AXI ready/valid inputs tied high.

Reset
REQ-030 With rst_ni=0 at a clock edge: state=IDLE; all AXI valid outputs, b_ready, r_ready, pready, pslverr = 0; prdata and capture registers = 0. Reset mid-transaction SHALL abandon the transaction at that edge.

Configuration
REQ-031 Macro APB2AXI_PSTRB_EN defined: s00_pstrb exists and drives the w_strb lane; a write with pstrb=0 SHALL still be issued.
REQ-032 Macro APB2AXI_PSTRB_EN undefined: s00_pstrb is absent and the w_strb lane is 4'hF.

Verification
REQ-033 Write 0x1000 with data 0xDEADBEEF, all ready inputs high, b_resp=OKAY -> one AW (addr 0x1000) and one W (strb 0xF, last 1); pready 4 cycles after setup; pslverr=0.
REQ-034 Read 0x2004 with AXI64 and r_data=0x11112222_33334444 -> ar_addr 0x2004; prdata=0x11112222; pslverr=0.
REQ-035 Write with w_ready delayed 3 cycles after aw_ready -> aw_valid drops after its handshake, w_valid held 3 more cycles, exactly one B accepted.
REQ-036 Read with r_resp=SLVERR (2'b10) -> pready with pslverr=1; next transfer has pslverr=0.
REQ-037 rst_ni low for 1 cycle while in WR_RESP -> all valid/ready outputs 0 the next cycle; FSM accepts a new setup phase immediately.
REQ-038 APB2AXI_PSTRB_EN with pstrb=4'b0101 at paddr 0x4 and AXI64 -> w_strb=8'b0101_0000.

Source files
------------

// File: rtl/apb2axi_bridge.sv
// APB slave to AXI4 master bridge: one single-beat transfer in flight at a time.
// Define APB2AXI_PSTRB_EN to add the APB4 s00_pstrb input; otherwise writes use full strobes.
module apb2axi_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned APB_ADDR_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // APB slave
  input  logic [APB_ADDR_WIDTH-1:0]   s00_paddr,
  input  logic [31:0]                 s00_pwdata,
  input  logic                        s00_pwrite,
  input  logic                        s00_psel,
  input  logic                        s00_penable,
`ifdef APB2AXI_PSTRB_EN
  input  logic [3:0]                  s00_pstrb,
`endif
  output logic [31:0]                 s00_prdata,
  output logic                        s00_pready,
  output logic                        s00_pslverr,
  // AXI write address
  output logic [AXI_ID_WIDTH-1:0]     m00_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0]   m00_aw_addr,
  output logic [7:0]                  m00_aw_len,
  output logic [2:0]                  m00_aw_size,
  output logic [1:0]                  m00_aw_burst,
  output logic                        m00_aw_lock,
  output logic [3:0]                  m00_aw_cache,
  output logic [2:0]                  m00_aw_prot,
  output logic [3:0]                  m00_aw_qos,
  output logic [3:0]                  m00_aw_region,
  output logic [AXI_USER_WIDTH-1:0]   m00_aw_user,
  output logic                        m00_aw_valid,
  input  logic                        m00_aw_ready,
  // AXI write data
  output logic [AXI_DATA_WIDTH-1:0]   m00_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] m00_w_strb,
  output logic                        m00_w_last,
  output logic                        m00_w_valid,
  input  logic                        m00_w_ready,
  // AXI write response
  input  logic [AXI_ID_WIDTH-1:0]     m00_b_id,
  input  logic [1:0]                  m00_b_resp,
  input  logic [AXI_USER_WIDTH-1:0]   m00_b_user,
  input  logic                        m00_b_valid,
  output logic                        m00_b_ready,
  // AXI read address
  output logic [AXI_ID_WIDTH-1:0]     m00_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0]   m00_ar_addr,
  output logic [7:0]                  m00_ar_len,
  output logic [2:0]                  m00_ar_size,
  output logic [1:0]                  m00_ar_burst,
  output logic                        m00_ar_lock,
  output logic [3:0]                  m00_ar_cache,
  output logic [2:0]                  m00_ar_prot,
  output logic [3:0]                  m00_ar_qos,
  output logic [3:0]                  m00_ar_region,
  output logic [AXI_USER_WIDTH-1:0]   m00_ar_user,
  output logic                        m00_ar_valid,
  input  logic                        m00_ar_ready,
  // AXI read data
  input  logic [AXI_ID_WIDTH-1:0]     m00_r_id,
  input  logic [AXI_DATA_WIDTH-1:0]   m00_r_data,
  input  logic [1:0]                  m00_r_resp,
  input  logic                        m00_r_last,
  input  logic [AXI_USER_WIDTH-1:0]   m00_r_user,
  input  logic                        m00_r_valid,
  output logic                        m00_r_ready
);

  typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StDone} state_e;

  state_e                    state_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]               pwdata_q;
  logic [3:0]                pstrb_q;
  logic [31:0]               rdata_q;
  logic [1:0]                resp_q;
  logic                      aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q, pready_q;
  logic [3:0]                pstrb_in;
  logic [31:0]               rlane;
  logic [AXI_ADDR_WIDTH-1:0] axi_addr;

`ifdef APB2AXI_PSTRB_EN
  assign pstrb_in = s00_pstrb;
`else
  assign pstrb_in = 4'hF;
`endif

  // Word-aligned address, zero-extended or truncated to the AXI width.
  if (AXI_ADDR_WIDTH > APB_ADDR_WIDTH) begin : g_addr_ext
    assign axi_addr = {{(AXI_ADDR_WIDTH - APB_ADDR_WIDTH){1'b0}},
                       paddr_q[APB_ADDR_WIDTH-1:2], 2'b00};
  end else begin : g_addr_trunc
    assign axi_addr = {paddr_q[AXI_ADDR_WIDTH-1:2], 2'b00};
  end

  if (AXI_DATA_WIDTH == 64) begin : g_axi64
    assign m00_w_strb = paddr_q[2] ? {pstrb_q, 4'h0} : {4'h0, pstrb_q};
    assign rlane      = paddr_q[2] ? m00_r_data[63:32] : m00_r_data[31:0];
  end else begin : g_axi32
    assign m00_w_strb = pstrb_q;
    assign rlane      = m00_r_data[31:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      rdata_q    <= '0;
      resp_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      pready_q   <= 1'b0;
    end else begin
      pready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Only a genuine setup phase starts a transfer.
          if (s00_psel && !s00_penable) begin
            paddr_q  <= s00_paddr;
            pwdata_q <= s00_pwdata;
            pstrb_q  <= pstrb_in;
            rdata_q  <= '0;
            resp_q   <= '0;
            if (s00_pwrite) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= StWrReq;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= StRdReq;
            end
          end
        end
        StWrReq: begin
          if (m00_aw_ready) aw_valid_q <= 1'b0;
          if (m00_w_ready)  w_valid_q  <= 1'b0;
          if ((!aw_valid_q || m00_aw_ready) && (!w_valid_q || m00_w_ready)) begin
            b_ready_q <= 1'b1;
            state_q   <= StWrResp;
          end
        end
        StWrResp: begin
          if (m00_b_valid) begin
            resp_q    <= m00_b_resp;
            b_ready_q <= 1'b0;
            pready_q  <= 1'b1;
            state_q   <= StDone;
          end
        end
        StRdReq: begin
          if (m00_ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= StRdResp;
          end
        end
        StRdResp: begin
          if (m00_r_valid) begin
            rdata_q   <= rlane;
            resp_q    <= m00_r_resp;
            r_ready_q <= 1'b0;
            pready_q  <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // A master that dropped psel before completion never sees pready.
  assign s00_pready  = pready_q & s00_psel;
  assign s00_pslverr = s00_pready & resp_q[1];
  assign s00_prdata  = rdata_q;

  assign m00_aw_addr   = axi_addr;
  assign m00_aw_valid  = aw_valid_q;
  assign m00_aw_id     = '0;
  assign m00_aw_len    = 8'd0;
  assign m00_aw_size   = 3'b010;
  assign m00_aw_burst  = 2'b01;
  assign m00_aw_lock   = 1'b0;
  assign m00_aw_cache  = 4'd0;
  assign m00_aw_prot   = 3'd0;
  assign m00_aw_qos    = 4'd0;
  assign m00_aw_region = 4'd0;
  assign m00_aw_user   = '0;

  assign m00_w_data  = {(AXI_DATA_WIDTH / 32){pwdata_q}};
  assign m00_w_last  = 1'b1;
  assign m00_w_valid = w_valid_q;
  assign m00_b_ready = b_ready_q;

  assign m00_ar_addr   = axi_addr;
  assign m00_ar_valid  = ar_valid_q;
  assign m00_ar_id     = '0;
  assign m00_ar_len    = 8'd0;
  assign m00_ar_size   = 3'b010;
  assign m00_ar_burst  = 2'b01;
  assign m00_ar_lock   = 1'b0;
  assign m00_ar_cache  = 4'd0;
  assign m00_ar_prot   = 3'd0;
  assign m00_ar_qos    = 4'd0;
  assign m00_ar_region = 4'd0;
  assign m00_ar_user   = '0;
  assign m00_r_ready   = r_ready_q;

  logic unused_inputs;
  assign unused_inputs = ^{m00_b_id, m00_b_user, m00_r_id, m00_r_last, m00_r_user, paddr_q};

endmodule
